match_controller: RTL
=====================

Name: match_controller

Overview:
Round/match sequencer for the two-player board. It drives the board reset and an action-enable gate, runs the pre-round countdown and the round timer, and decides each round's winner from the lose flags or, on timeout, from health. It tallies round wins and declares the match winner. It sits between the top-level board wrapper and the board, runs on the fast clock, and uses a one-cycle tick from the frequency divider.

Parameters:
CNTDWN_TICKS, 3, ticks of countdown before a round starts (>=1)
ROUND_TICKS, 60, round time limit in ticks (>=1, <=127)
INTER_TICKS, 2, ticks of pause after a round ends (>=1)
WINS_TO_MATCH, 2, round wins needed to take the match (1..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-clk-wide enable pulse, one per slow-clock period
start  in  1  start/restart request, level; rising edge detected internally
plr_1_lst  in  1  player 1 lost (health exhausted), from board
plr_2_lst  in  1  player 2 lost, from board
plr_1_hlt  in  2  player 1 encoded health, from board (larger = healthier)
plr_2_hlt  in  2  player 2 encoded health, from board
brd_rst  out  1  reset to board; board must see it across a slow-clock edge
act_en  out  1  1 = player actions forwarded to board; 0 = actions forced to idle
time_left  out  7  round ticks remaining (countdown ticks during COUNTDOWN)
plr_1_wins  out  2  rounds won by player 1
plr_2_wins  out  2  rounds won by player 2
rnd_rslt  out  2  last round result: 00 none, 01 P1, 10 P2, 11 draw
match_over  out  1  match decided
match_wnr  out  2  00 none, 01 P1, 10 P2
state  out  3  current FSM state, for display/debug

Behaviour:
- Reset, synchronous and active-high: state=IDLE, brd_rst=1, act_en=0, time_left=0, wins=0, rnd_rslt=00, match_over=0, match_wnr=00, start edge register=0.
- start_pe = start & ~start_q; start_q is registered every cycle.
- Outputs are Moore, decoded from the state register. brd_rst=1 in IDLE and CLEAR only. act_en=1 in FIGHT only. match_over=1 in MATCH_END only.
- IDLE (0): start_pe -> CLEAR; wins, rnd_rslt and match_wnr are cleared.
- CLEAR (1): stays until tick, so the board reset spans at least one slow edge. On tick -> COUNTDOWN and time_left <= CNTDWN_TICKS.
- COUNTDOWN (2): time_left decrements on each tick. On a tick with time_left==1 -> FIGHT and time_left <= ROUND_TICKS.
- FIGHT (3): evaluated every clk, in priority order:
  - plr_1_lst & plr_2_lst -> draw (11).
  - plr_1_lst -> P2 (10).
  - plr_2_lst -> P1 (01).
  - tick & time_left==1 -> timeout: higher health wins; equal health -> draw.
  - otherwise, on tick, time_left decrements.
  - Lose flags beat timeout in the same cycle.
  - On any result: rnd_rslt is registered, the winner's count is incremented (draw increments nothing), time_left <= INTER_TICKS, -> ROUND_END.
- ROUND_END (4): time_left decrements on tick. On a tick with time_left==1: if either count == WINS_TO_MATCH -> MATCH_END with match_wnr set, else -> CLEAR.
  - Only one count can change per round, so both players never reach the target together.
  - Draws replay without limit.
- MATCH_END (5): holds all outputs. start_pe -> CLEAR; wins and rnd_rslt are cleared, match_wnr -> 00.
- start_pe outside IDLE and MATCH_END is ignored (no mid-round restart). rst is the only abort.
- rst asserted mid-operation has immediate priority: next cycle is IDLE with reset values.
- Win counters never exceed WINS_TO_MATCH. Unused state encodings recover to IDLE.

Decomposition:
- Shared game package: state encoding localparams (IDLE..MATCH_END), rnd_rslt/match_wnr codes (NONE, P1, P2, DRAW), health width (2).
- One natural sub-module: tick_counter, a loadable down-counter with tick enable and a "last" flag (time_left==1 & tick). It is reused for the countdown, round and intermission phases.
- The board-side act_en gate (act ANDed with act_en, idle encoding otherwise) lives in the top-level wrapper, not in this block.

Test Plan:
(Params: CNTDWN_TICKS=3, ROUND_TICKS=5, INTER_TICKS=2, WINS_TO_MATCH=2; tick every 4 clks.)
- rst held 3 clks, then start held high 20 clks -> one start edge only. CLEAR until first tick. COUNTDOWN shows 3,2,1. FIGHT entered on 3rd countdown tick with time_left=5, act_en=1, brd_rst=0.
- In FIGHT, pulse plr_2_lst at time_left=4 -> next clk ROUND_END, rnd_rslt=01, plr_1_wins=1, act_en=0. After 2 ticks -> CLEAR, brd_rst=1.
- No lose flags, hlt1=2, hlt2=3, 5 ticks elapse -> rnd_rslt=10, plr_2_wins=1. Repeat with hlt1=hlt2=1 -> rnd_rslt=11, wins unchanged.
- plr_1_lst, plr_2_lst and the timeout tick all in the same cycle -> draw (11), no count changes.
- P1 wins two rounds -> MATCH_END, match_over=1, match_wnr=01, plr_1_wins=2. Outputs held for 50 clks. start edge -> CLEAR with wins=0, match_wnr=00.
- rst asserted during FIGHT with plr_1_wins=1 -> next clk state=IDLE, wins=0, brd_rst=1, act_en=0. start edge in FIGHT (no rst) -> ignored.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared game definitions for the match sequencer: FSM states, round/match
// result codes and board field widths.
package match_controller_pkg;

    localparam int unsigned HLT_W  = 2;
    localparam int unsigned TIME_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_FIGHT     = 3'd3,
        ST_ROUND_END = 3'd4,
        ST_MATCH_END = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_e;

    // Timeout decision: healthier player takes the round, equal health is a draw.
    function automatic result_e health_winner(input logic [HLT_W-1:0] h1,
                                              input logic [HLT_W-1:0] h2);
        if (h1 > h2)      return RES_P1;
        else if (h1 < h2) return RES_P2;
        else              return RES_DRAW;
    endfunction

endpackage

// File: rtl/match_controller_tick_counter.sv
// Loadable down-counter advanced by the slow tick; flags the tick on which it
// leaves the value 1. Shared by the countdown, round and intermission phases.
module tick_counter
    import match_controller_pkg::*;
#(
    parameter int unsigned WIDTH = TIME_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (en_i && tick_i && (count_q != '0))
            count_d = count_q - ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
    assign last_o  = en_i & tick_i & (count_q == ONE);

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: gates the board, times countdown/round/intermission,
// decides each round and tallies wins until one player takes the match.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int unsigned CNTDWN_TICKS  = 3,
    parameter int unsigned ROUND_TICKS   = 60,
    parameter int unsigned INTER_TICKS   = 2,
    parameter int unsigned WINS_TO_MATCH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       plr_1_lst,
    input  logic       plr_2_lst,
    input  logic [1:0] plr_1_hlt,
    input  logic [1:0] plr_2_hlt,
    output logic       brd_rst,
    output logic       act_en,
    output logic [6:0] time_left,
    output logic [1:0] plr_1_wins,
    output logic [1:0] plr_2_wins,
    output logic [1:0] rnd_rslt,
    output logic       match_over,
    output logic [1:0] match_wnr,
    output logic [2:0] state
);

    localparam logic [TIME_W-1:0] CNTDWN_VAL = TIME_W'(CNTDWN_TICKS);
    localparam logic [TIME_W-1:0] ROUND_VAL  = TIME_W'(ROUND_TICKS);
    localparam logic [TIME_W-1:0] INTER_VAL  = TIME_W'(INTER_TICKS);
    localparam logic [1:0]        WINS_VAL   = 2'(WINS_TO_MATCH);

    state_e     state_q, state_d;
    logic       start_q;
    logic [1:0] p1_wins_q, p1_wins_d;
    logic [1:0] p2_wins_q, p2_wins_d;
    result_e    rslt_q, rslt_d;
    result_e    wnr_q, wnr_d;
    result_e    fight_rslt;

    logic              start_pe;
    logic              cnt_en;
    logic              cnt_load;
    logic [TIME_W-1:0] cnt_val;
    logic [TIME_W-1:0] cnt_value;
    logic              cnt_last;

    assign start_pe = start & ~start_q;

    tick_counter #(.WIDTH(TIME_W)) u_tick_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_i     (tick),
        .en_i       (cnt_en),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .count_o    (cnt_value),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        p1_wins_d  = p1_wins_q;
        p2_wins_d  = p2_wins_q;
        rslt_d     = rslt_q;
        wnr_d      = wnr_q;
        fight_rslt = RES_NONE;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;

        case (state_q)
            ST_IDLE, ST_MATCH_END: begin
                if (start_pe) begin
                    state_d   = ST_CLEAR;
                    p1_wins_d = '0;
                    p2_wins_d = '0;
                    rslt_d    = RES_NONE;
                    wnr_d     = RES_NONE;
                end
            end
            ST_CLEAR: begin
                if (tick) begin
                    state_d  = ST_COUNTDOWN;
                    cnt_load = 1'b1;
                    cnt_val  = CNTDWN_VAL;
                end
            end
            ST_COUNTDOWN: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d  = ST_FIGHT;
                    cnt_load = 1'b1;
                    cnt_val  = ROUND_VAL;
                end
            end
            ST_FIGHT: begin
                cnt_en = 1'b1;
                // Lose flags outrank the timeout tick in the same cycle.
                if (plr_1_lst && plr_2_lst) fight_rslt = RES_DRAW;
                else if (plr_1_lst)         fight_rslt = RES_P2;
                else if (plr_2_lst)         fight_rslt = RES_P1;
                else if (cnt_last)          fight_rslt = health_winner(plr_1_hlt, plr_2_hlt);

                if (fight_rslt != RES_NONE) begin
                    state_d  = ST_ROUND_END;
                    rslt_d   = fight_rslt;
                    cnt_load = 1'b1;
                    cnt_val  = INTER_VAL;
                    if (fight_rslt == RES_P1 && p1_wins_q != WINS_VAL)
                        p1_wins_d = p1_wins_q + 2'd1;
                    if (fight_rslt == RES_P2 && p2_wins_q != WINS_VAL)
                        p2_wins_d = p2_wins_q + 2'd1;
                end
            end
            ST_ROUND_END: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    if (p1_wins_q == WINS_VAL) begin
                        state_d = ST_MATCH_END;
                        wnr_d   = RES_P1;
                    end else if (p2_wins_q == WINS_VAL) begin
                        state_d = ST_MATCH_END;
                        wnr_d   = RES_P2;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            p1_wins_q <= '0;
            p2_wins_q <= '0;
            rslt_q    <= RES_NONE;
            wnr_q     <= RES_NONE;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            p1_wins_q <= p1_wins_d;
            p2_wins_q <= p2_wins_d;
            rslt_q    <= rslt_d;
            wnr_q     <= wnr_d;
        end
    end

    assign state      = state_q;
    assign brd_rst    = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign act_en     = (state_q == ST_FIGHT);
    assign match_over = (state_q == ST_MATCH_END);
    assign time_left  = cnt_value;
    assign plr_1_wins = p1_wins_q;
    assign plr_2_wins = p2_wins_q;
    assign rnd_rslt   = rslt_q;
    assign match_wnr  = wnr_q;

endmodule
